// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - period and high-time meter for a slow asynchronous periodic signal
// Counts Clk cycles between synchronised rising edges of SigIn and flags a stalled input.
module clk_period_meter #(
    parameter int CNT_W       = 27,
    parameter int TIMEOUT     = 120000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             SigIn,
    output logic [CNT_W-1:0] Period,
    output logic [CNT_W-1:0] HighTime,
    output logic             Valid,
    output logic             Timeout,
    output logic             Busy
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO_C    = '0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOW  = 2'd1,
        WAIT_RISE = 2'd2,
        MEASURE   = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] syncQ;
    logic                   sD;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   pipeLow;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       hcnt;

    assign s    = syncQ[SYNC_STAGES-1];
    assign rise = s & ~sD;
    assign fall = ~s & sD;
    // The whole synchroniser must read low, so a high level still in flight
    // after reset or enable is not mistaken for a low and then a fresh edge.
    assign pipeLow = ~(|syncQ) & ~sD;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            syncQ <= '0;
            sD    <= 1'b0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], SigIn};
            sD    <= s;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            cnt      <= ZERO_C;
            hcnt     <= ZERO_C;
            Period   <= ZERO_C;
            HighTime <= ZERO_C;
            Valid    <= 1'b0;
            Timeout  <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            Valid <= 1'b0;
            if (!En) begin
                state   <= IDLE;
                cnt     <= ZERO_C;
                hcnt    <= ZERO_C;
                Timeout <= 1'b0;
                Busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt   <= ZERO_C;
                        state <= WAIT_LOW;
                        Busy  <= 1'b1;
                    end
                    WAIT_LOW: begin
                        if (pipeLow) begin
                            state <= WAIT_RISE;
                        end
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            cnt   <= ONE_C;
                            hcnt  <= ZERO_C;
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            Period   <= cnt;
                            HighTime <= hcnt;
                            Valid    <= 1'b1;
                            Timeout  <= 1'b0;
                            cnt      <= ONE_C;
                            hcnt     <= ZERO_C;
                        end else if (cnt == TIMEOUT_C) begin
                            // Results stay at the last good measurement; re-arm from a clean low.
                            Timeout <= 1'b1;
                            cnt     <= ZERO_C;
                            state   <= WAIT_LOW;
                        end else begin
                            cnt <= cnt + ONE_C;
                            if (fall) begin
                                hcnt <= cnt;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
